// File: rtl/ghist_speculative_manager.sv
// Speculative global-history register with an in-order checkpoint FIFO for misprediction recovery.
// Optional sticky protocol-error output is enabled by defining GHIST_PROTOCOL_ERR_EN.
module ghist_speculative_manager #(
  parameter int GlobLen = 131,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               pred_valid,
  input  logic               pred_taken,
  output logic               pred_ready,
  input  logic               resolve_valid,
  input  logic               resolve_mispredict,
  input  logic               resolve_taken,
  output logic [GlobLen-1:0] ghist,
  output logic               index_tag_enable,
  output logic [PTR_W:0]     inflight_count,
  output logic               full,
`ifdef GHIST_PROTOCOL_ERR_EN
  output logic               empty,
  output logic               proto_err
`else
  output logic               empty
`endif
);

  localparam logic [PTR_W:0]   LP_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = (PTR_W)'(1);

  logic [GlobLen-1:0] r_ckpt [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic [GlobLen-1:0] r_ghist;
  logic               r_itena;

  logic               w_full;
  logic               w_empty;
  logic               w_flush;
  logic               w_pop;
  logic               w_accept;
  logic [GlobLen-1:0] w_head_ckpt;
  logic [PTR_W:0]     w_count_next;
  logic [GlobLen-1:0] w_ghist_next;

  assign w_full      = (r_count == LP_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_flush     = resolve_valid & resolve_mispredict & ~w_empty;
  assign w_pop       = resolve_valid & ~resolve_mispredict & ~w_empty;
  // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
  assign w_accept    = pred_valid & ~w_full & ~w_flush;
  assign w_head_ckpt = r_ckpt[r_head];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    w_ghist_next = r_ghist;
    if (w_flush) begin
      w_count_next = '0;
      w_ghist_next = {w_head_ckpt[GlobLen-2:0], resolve_taken};
    end else begin
      if (w_accept && !w_pop) w_count_next = r_count + LP_CNT_ONE;
      if (!w_accept && w_pop) w_count_next = r_count - LP_CNT_ONE;
      if (w_accept)           w_ghist_next = {r_ghist[GlobLen-2:0], pred_taken};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ghist <= '0;
      r_itena <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_ghist <= w_ghist_next;
      r_itena <= w_accept | w_flush;
      if (w_flush) begin
        r_head <= r_head + LP_PTR_ONE;
        r_tail <= r_head + LP_PTR_ONE;
      end else begin
        if (w_pop)    r_head <= r_head + LP_PTR_ONE;
        if (w_accept) r_tail <= r_tail + LP_PTR_ONE;
      end
    end
  end

  // NOTE: checkpoint storage has no reset; entries are only read after being written, so it can map to LUT RAM.
  always_ff @(posedge CLK) begin
    if (w_accept) r_ckpt[r_tail] <= r_ghist;
  end

`ifdef GHIST_PROTOCOL_ERR_EN
  logic r_proto_err;
  logic w_proto_evt;

  assign w_proto_evt = (resolve_valid & w_empty) | (pred_valid & w_full & ~w_flush);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)           r_proto_err <= 1'b0;
    else if (w_proto_evt) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;
`endif

  assign pred_ready       = ~w_full & ~w_flush;
  assign ghist            = r_ghist;
  assign index_tag_enable = r_itena;
  assign inflight_count   = r_count;
  assign full             = w_full;
  assign empty            = w_empty;

endmodule

// File: tb/tb_ghist_speculative_manager.sv
// Scoreboard bench for ghist_speculative_manager: stimulus pushes expected history/count,
// a negedge monitor pops and compares whenever index_tag_enable is high.
module tb_ghist_speculative_manager;

  localparam int GlobLen = 131;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;

  typedef struct {
    logic [GlobLen-1:0] g;
    logic [PTR_W:0]     c;
  } exp_t;

  logic               CLK = 1'b0;
  logic               reset = 1'b0;
  logic               pred_valid = 1'b0;
  logic               pred_taken = 1'b0;
  logic               pred_ready;
  logic               resolve_valid = 1'b0;
  logic               resolve_mispredict = 1'b0;
  logic               resolve_taken = 1'b0;
  logic [GlobLen-1:0] ghist;
  logic               index_tag_enable;
  logic [PTR_W:0]     inflight_count;
  logic               full;
  logic               empty;
`ifdef GHIST_PROTOCOL_ERR_EN
  logic               proto_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  exp_t               exp_q[$];
  logic [GlobLen-1:0] m_q[$];
  logic [GlobLen-1:0] m_ghist = '0;
  logic [GlobLen-1:0] saved;

  ghist_speculative_manager #(.GlobLen(GlobLen), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK                (CLK),
    .reset              (reset),
    .pred_valid         (pred_valid),
    .pred_taken         (pred_taken),
    .pred_ready         (pred_ready),
    .resolve_valid      (resolve_valid),
    .resolve_mispredict (resolve_mispredict),
    .resolve_taken      (resolve_taken),
    .ghist              (ghist),
    .index_tag_enable   (index_tag_enable),
    .inflight_count     (inflight_count),
    .full               (full),
`ifdef GHIST_PROTOCOL_ERR_EN
    .empty              (empty),
    .proto_err          (proto_err)
`else
    .empty              (empty)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [GlobLen-1:0] act, input logic [GlobLen-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each index_tag_enable pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (reset && index_tag_enable) begin
      if (exp_q.size() == 0) begin
        check("itena_unexpected", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ghist", ghist, e.g);
        check("sb_count", {{(GlobLen-PTR_W-1){1'b0}}, inflight_count}, {{(GlobLen-PTR_W-1){1'b0}}, e.c});
      end
    end
  end

  // One clock of stimulus; reference model of the FIFO is updated alongside.
  task automatic step(input logic pv, input logic pt, input logic rv, input logic rm, input logic rt);
    bit m_flush, m_full, m_accept, m_pop;
    pred_valid = pv; pred_taken = pt;
    resolve_valid = rv; resolve_mispredict = rm; resolve_taken = rt;
    m_flush  = rv & rm & (m_q.size() != 0);
    m_full   = (m_q.size() == DEPTH);
    m_accept = pv & !m_full & !m_flush;
    m_pop    = rv & !rm & (m_q.size() != 0);
    #1;
    check("pred_ready", pred_ready, !m_full & !m_flush);
    if (m_flush) begin
      m_ghist = {m_q[0][GlobLen-2:0], rt};
      m_q.delete();
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_accept) begin
        m_q.push_back(m_ghist);
        m_ghist = {m_ghist[GlobLen-2:0], pt};
      end
    end
    if (m_accept || m_flush) exp_q.push_back('{g: m_ghist, c: (PTR_W+1)'(m_q.size())});
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("itena_missing", exp_q.size(), 0);
    pred_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ghist"}, ghist, '0);
    check({tag, "_itena"}, index_tag_enable, 1'b0);
    check({tag, "_count"}, inflight_count, 0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_full"},  full, 1'b0);
    check({tag, "_ready"}, pred_ready, 1'b1);
`ifdef GHIST_PROTOCOL_ERR_EN
    check({tag, "_perr"}, proto_err, 1'b0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pred_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    m_q.delete();
    exp_q.delete();
    m_ghist = '0;
    check_reset_values("rst");
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Resolve while empty: no flush, no state change.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("empty_res_ghist", ghist, '0);
    check("empty_res_count", inflight_count, 0);
`ifdef GHIST_PROTOCOL_ERR_EN
    check("empty_res_perr", proto_err, 1'b1);
`endif

    // Reset then accept 1,0,1.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_ghist", ghist, 131'b101);
    check("t1_count", inflight_count, 3);

    // Fill to full, then a dropped 9th prediction.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b0, 1'b0);
    check("full_flag", full, 1'b1);
    check("full_ready", pred_ready, 1'b0);
    check("full_ghist", ghist, 131'h55);
`ifdef GHIST_PROTOCOL_ERR_EN
    check("full_perr_before", proto_err, 1'b0);
`endif
    saved = ghist;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_drop_ghist", ghist, saved);
    check("full_drop_count", inflight_count, 8);
`ifdef GHIST_PROTOCOL_ERR_EN
    check("full_perr_after", proto_err, 1'b1);
`endif

    // Accept + correct resolve at count 8: pop only, then push+pop holds the count.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sim_pop_cnt", inflight_count, 7);
    check("sim_pop_ghist", ghist, 131'h55);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sim_both_cnt", inflight_count, 7);
    check("sim_both_ghist", ghist, 131'hAB);

    // Mispredict recovery with a concurrent prediction that must be refused.
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mp_pre_ghist", ghist, 131'hF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mp_ghist", ghist, '0);
    check("mp_count", inflight_count, 0);
    check("mp_empty", empty, 1'b1);

    // Pointer wrap: 20 accept/correct-resolve pairs, then mispredict the oldest.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'(((i * 5) >> 1) & 1), 1'b1, 1'b0, 1'b0);
    check("wrap_count", inflight_count, 1);
    saved = {m_q[0][GlobLen-2:0], 1'b1};
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("wrap_restore", ghist, saved);
    check("wrap_count_after", inflight_count, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_post_accept", ghist, {saved[GlobLen-2:0], 1'b0});

    // Asynchronous reset between edges with five in flight.
    do_reset();
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ar_pre_count", inflight_count, 5);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ghist_speculative_manager.md
# ghist_speculative_manager

Speculative global branch-history register with in-order checkpoint recovery. It sits directly upstream of the TAGE index/tag generator and drives that stage's 131-bit `ghist` and `index_tag_enable` inputs. The block shifts predicted outcomes into history and checkpoints the pre-shift value of every in-flight branch. On a misprediction it restores the correct history from the checkpoint.

## Interface
- `GlobLen`, 131: global history length; must equal the index/tag generator's `GlobLen`.
- `DEPTH`, 8: checkpoint FIFO entries (max in-flight branches); power of two, ≥2.
- `PTR_W`, 3: log2(`DEPTH`).

- `CLK` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `pred_valid` input 1: new prediction offered.
- `pred_taken` input 1: predicted direction, 1 = taken.
- `pred_ready` output 1: prediction accepted this cycle when high with `pred_valid`.
- `resolve_valid` input 1: oldest in-flight branch resolves this cycle.
- `resolve_mispredict` input 1: oldest branch was mispredicted; qualified by `resolve_valid`.
- `resolve_taken` input 1: actual direction of the oldest branch.
- `ghist` output `GlobLen`: speculative history, bit 0 = most recent outcome.
- `index_tag_enable` output 1: one-cycle pulse while `ghist` holds a newly updated value.
- `inflight_count` output `PTR_W+1`: number of occupied checkpoints, 0..`DEPTH`.
- `full` output 1: `inflight_count == DEPTH`.
- `empty` output 1: `inflight_count == 0`.

## Operation
- **Reset values (asynchronous):**
  - `ghist` = 0.
  - `index_tag_enable` = 0.
  - Head/tail pointers = 0.
  - `inflight_count` = 0, so `empty` = 1, `full` = 0, `pred_ready` = 1.
  - Checkpoint storage is not reset.
- **Flush:** `flush = resolve_valid & resolve_mispredict & !empty`.
- **Ready:** `pred_ready = !full & !flush`, combinational.
- **Accept:** `accept = pred_valid & pred_ready`.
  - The current `ghist` is written to checkpoint[tail]; tail increments modulo `DEPTH`.
  - `ghist <= {ghist[GlobLen-2:0], pred_taken}`.
- **Correct resolve** (`resolve_valid & !resolve_mispredict & !empty`): head increments modulo `DEPTH`; `ghist` is unchanged by the resolve.
- **Mispredict resolve (flush):**
  - `ghist <= {checkpoint[head][GlobLen-2:0], resolve_taken}`.
  - All younger entries are discarded: tail <= head+1, head <= head+1, count <= 0.
- **Simultaneous events:**
  - Accept + correct resolve: push and pop both happen; count is unchanged; `ghist` shifts.
  - Prediction + flush: flush wins and the prediction is not accepted (`pred_ready` = 0).
  - Full + correct resolve: no accept that cycle, because `full` is taken from the registered count.
- **Count update:** `count_next = count + accept − (correct resolve)` when there is no flush; 0 on flush.
- **Resolve while empty:** ignored; no state change.
- **`index_tag_enable`:** registered. It is 1 in the cycle after any cycle with `accept` or `flush`, otherwise 0.
- **Reset mid-operation:** all in-flight checkpoints are lost; history returns to 0 immediately.

## Timing
- Edge N: accept or flush is sampled.
- Edge N+1 output: new `ghist` is visible and `index_tag_enable` = 1 for exactly that one cycle.
- The downstream index/tag registers capture at edge N+2.
- Back-to-back accepts give consecutive shifts and `index_tag_enable` stays high continuously.
- `pred_ready` has a combinational path from `resolve_valid`/`resolve_mispredict`. All other outputs are registered.
- Checkpoint read at head is combinational from storage (register array or LUT RAM).

## Configuration
- `GHIST_PROTOCOL_ERR_EN`
  - **Defined:** adds output `proto_err` (1 bit, reset 0, sticky until reset). It sets on:
    - `resolve_valid` while `empty`;
    - `pred_valid & full & !flush`, i.e. a prediction dropped because the FIFO is full.
  - **Undefined:** the port and logic are absent, and those events are silently ignored.

## Test plan
- **Reset then accept:** accept `pred_taken` = 1,0,1 on consecutive cycles → `ghist[2:0]` = 3'b101, `inflight_count` = 3, `index_tag_enable` high for 3 cycles.
- **Fill to full:** accept 8 predictions → `full` = 1, `pred_ready` = 0. A 9th `pred_valid` leaves `ghist` unchanged (and sets `proto_err` when `GHIST_PROTOCOL_ERR_EN` is defined).
- **Mispredict recovery:** `ghist` = 0, accept taken ×4, then resolve oldest with mispredict and `resolve_taken` = 0 → `ghist` = 0, `inflight_count` = 0, `index_tag_enable` pulses once.
- **Simultaneous accept + correct resolve at count 8:**
  - Pop occurs and no push → count 7.
  - Next cycle: accept + correct resolve → count stays 7.
- **Pointer wrap:** run 20 accept/correct-resolve pairs, then mispredict the oldest → restored history equals that branch's checkpointed pre-shift history with `resolve_taken` appended.
- **Async reset mid-flight:** assert `reset` low between clock edges with count 5 → all outputs take reset values immediately, without a clock edge.
